dsp_fir_result_collector: RTL and testbench

Output-side companion to a dsp_t1 MAC configured as a time-multiplexed FIR filter (OUTPUT_SELECT=1, accumulator output).
- Watches the accumulator dump strobe, the same signal that drives the DSP feedback_i.
- Captures z_o on each dump, saturates it to the output sample width and queues it in a small FIFO.
- Presents the queue on a valid/ready stream to downstream logic.
- Sits between the dsp_t1 instance and the filter's consumer (decimator, serializer or CPU-readable buffer).

---
 rtl/dsp_fir_result_collector.sv | 124 ++++++++++++
 tb/tb_dsp_fir_result_collector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_fir_result_collector.sv
// Output collector for a time-multiplexed FIR on a dsp_t1 MAC: captures z_o on dump,
// saturates it to OUT_WIDTH and queues it on a valid/ready stream. Optional stats: DSP_FIR_COLLECT_STATS_EN.
module dsp_fir_result_collector #(
  parameter int Z_WIDTH         = 38,
  parameter int OUT_WIDTH       = 32,
  parameter int DEPTH           = 4,
  parameter int CAPTURE_LATENCY = 0
) (
  input  logic                       clock_i,
  input  logic                       s_reset,
  input  logic                       dump_i,
  input  logic [Z_WIDTH-1:0]         z_i,
  output logic [OUT_WIDTH-1:0]       m_data_o,
  output logic                       m_sat_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
`ifdef DSP_FIR_COLLECT_STATS_EN
  output logic [15:0]                sample_count_o,
  output logic [15:0]                sat_count_o,
`endif
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic cap;

  generate
    if (CAPTURE_LATENCY == 0) begin : g_direct
      assign cap = dump_i;
    end else begin : g_delay
      logic [CAPTURE_LATENCY-1:0] dly;
      always_ff @(posedge clock_i) begin
        if (s_reset) begin
          dly <= '0;
        end else begin
          dly[0] <= dump_i;
          for (int i = 1; i < CAPTURE_LATENCY; i++) dly[i] <= dly[i-1];
        end
      end
      assign cap = dly[CAPTURE_LATENCY-1];
    end
  endgenerate

  // Value fits when every bit from the output sign bit upward agrees.
  logic [Z_WIDTH-OUT_WIDTH:0] upper;
  logic                       fits;
  logic [OUT_WIDTH-1:0]       wr_data;
  logic                       wr_sat;

  always_comb begin
    upper   = z_i[Z_WIDTH-1:OUT_WIDTH-1];
    fits    = (&upper) | ~(|upper);
    wr_data = z_i[OUT_WIDTH-1:0];
    wr_sat  = 1'b0;
    if (!fits) begin
      wr_sat  = 1'b1;
      wr_data = z_i[Z_WIDTH-1] ? MIN_VAL : MAX_VAL;
    end
  end

  logic [OUT_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr, rd_next;
  logic [LW-1:0]      level, level_next, level_after_pop;
  logic               full, push, pop, head_load;
  logic [OUT_WIDTH:0] head_next;

  always_comb begin
    full            = (level == LW'(DEPTH));
    pop             = m_valid_o && m_ready_i;
    push            = cap && (!full || pop);
    rd_next         = rd_ptr + AW'(pop);
    level_after_pop = level - LW'(pop);
    level_next      = level_after_pop + LW'(push);
    // Head register reloads only when the visible entry changes; an emptied FIFO keeps the last sample.
    head_load       = (level_next != '0) && (pop || (level == '0));
    if (push && (level_after_pop == '0)) head_next = {wr_sat, wr_data};
    else                                 head_next = mem[rd_next];
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= {wr_sat, wr_data};
  end

  always_ff @(posedge clock_i) begin
    if (s_reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      m_data_o   <= '0;
      m_sat_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      level <= level_next;
      if (head_load) begin
        m_sat_o  <= head_next[OUT_WIDTH];
        m_data_o <= head_next[OUT_WIDTH-1:0];
      end
      if (cap && !push) overflow_o <= 1'b1;
    end
  end

  assign m_valid_o = (level != '0);
  assign level_o   = level;

`ifdef DSP_FIR_COLLECT_STATS_EN
  always_ff @(posedge clock_i) begin
    if (s_reset) begin
      sample_count_o <= '0;
      sat_count_o    <= '0;
    end else if (push) begin
      if (sample_count_o != 16'hFFFF) sample_count_o <= sample_count_o + 16'd1;
      if (wr_sat && (sat_count_o != 16'hFFFF)) sat_count_o <= sat_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_fir_result_collector.sv
// Directed bench for dsp_fir_result_collector: table of single-sample vectors plus
// hand-written backpressure, reset and capture-latency sequences.
module tb_dsp_fir_result_collector;

  logic        clk = 1'b0;
  logic        s_reset;
  logic        dump, ready;
  logic [37:0] z;
  logic [31:0] m_data;
  logic        m_sat, m_valid, overflow;
  logic [2:0]  level;

  logic        dump2, ready2;
  logic [37:0] z2;
  logic [31:0] m_data2;
  logic        m_sat2, m_valid2, overflow2;
  logic [2:0]  level2;

`ifdef DSP_FIR_COLLECT_STATS_EN
  logic [15:0] sample_count, sat_count, sample_count2, sat_count2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dsp_fir_result_collector dut (
    .clock_i(clk), .s_reset(s_reset), .dump_i(dump), .z_i(z),
    .m_data_o(m_data), .m_sat_o(m_sat), .m_valid_o(m_valid), .m_ready_i(ready),
    .level_o(level),
`ifdef DSP_FIR_COLLECT_STATS_EN
    .sample_count_o(sample_count), .sat_count_o(sat_count),
`endif
    .overflow_o(overflow)
  );

  dsp_fir_result_collector #(.CAPTURE_LATENCY(2)) dut_lat2 (
    .clock_i(clk), .s_reset(s_reset), .dump_i(dump2), .z_i(z2),
    .m_data_o(m_data2), .m_sat_o(m_sat2), .m_valid_o(m_valid2), .m_ready_i(ready2),
    .level_o(level2),
`ifdef DSP_FIR_COLLECT_STATS_EN
    .sample_count_o(sample_count2), .sat_count_o(sat_count2),
`endif
    .overflow_o(overflow2)
  );

  typedef struct {
    logic [37:0] z;
    logic [31:0] d;
    logic        s;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_reset = 1'b1;
    step();
    step();
    s_reset = 1'b0;
  endtask

  task automatic push_val(input logic [37:0] v);
    dump = 1'b1;
    z    = v;
    step();
    dump = 1'b0;
  endtask

  initial begin
    int nsat;
    vecs[0] = '{38'h36,           32'h36,       1'b0};
    vecs[1] = '{38'h6C,           32'h6C,       1'b0};
    vecs[2] = '{38'h0,            32'h0,        1'b0};
    vecs[3] = '{38'h0,            32'h0,        1'b0};
    vecs[4] = '{38'h00_8000_0000, 32'h7FFFFFFF, 1'b1};
    vecs[5] = '{38'h3F_0000_0000, 32'h80000000, 1'b1};
    vecs[6] = '{38'h3F_FFFF_FFFF, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{38'h00_7FFF_FFFF, 32'h7FFFFFFF, 1'b0};
    vecs[8] = '{38'h3F_8000_0000, 32'h80000000, 1'b0};

    s_reset = 1'b0; dump = 1'b0; ready = 1'b0; z = '0;
    dump2 = 1'b0; ready2 = 1'b0; z2 = '0;
    @(negedge clk);
    do_reset();
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_sat", 64'(m_sat), 64'd0);
    chk("rst_valid_lat2", 64'(m_valid2), 64'd0);

    // Single samples with ready held high: pushed while empty, popped on the next edge.
    ready = 1'b1;
    nsat = 0;
    for (int i = 0; i < 9; i++) begin
      push_val(vecs[i].z);
      chk($sformatf("vec%0d_valid", i), 64'(m_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(m_data), 64'(vecs[i].d));
      chk($sformatf("vec%0d_sat", i), 64'(m_sat), 64'(vecs[i].s));
      chk($sformatf("vec%0d_level", i), 64'(level), 64'd1);
      step();
      chk($sformatf("vec%0d_popped", i), 64'(level), 64'd0);
      chk($sformatf("vec%0d_hold", i), 64'(m_data), 64'(vecs[i].d));
      if (vecs[i].s) nsat++;
    end
`ifdef DSP_FIR_COLLECT_STATS_EN
    chk("stats_samples", 64'(sample_count), 64'd9);
    chk("stats_sats", 64'(sat_count), 64'(nsat));
`endif
    chk("table_no_overflow", 64'(overflow), 64'd0);

    // Backpressure: five back-to-back dumps into a 4-deep FIFO.
    do_reset();
    ready = 1'b0;
    dump = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      z = 38'(i);
      step();
    end
    dump = 1'b0;
    chk("bp_level", 64'(level), 64'd4);
    chk("bp_overflow", 64'(overflow), 64'd1);
    chk("bp_head", 64'(m_data), 64'd1);
    step();
    chk("bp_head_hold", 64'(m_data), 64'd1);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("bp_drain%0d_valid", i), 64'(m_valid), 64'd1);
      chk($sformatf("bp_drain%0d_data", i), 64'(m_data), 64'(i));
      step();
    end
    chk("bp_empty", 64'(m_valid), 64'd0);
    chk("bp_last_hold", 64'(m_data), 64'd4);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);

    // Reset mid-stream with a simultaneous dump: reset wins.
    ready = 1'b0;
    for (int i = 7; i <= 9; i++) push_val(38'(i));
    chk("rm_level3", 64'(level), 64'd3);
    s_reset = 1'b1; dump = 1'b1; z = 38'h5;
    step();
    s_reset = 1'b0; dump = 1'b0;
    chk("rm_valid", 64'(m_valid), 64'd0);
    chk("rm_level", 64'(level), 64'd0);
    chk("rm_overflow", 64'(overflow), 64'd0);
    chk("rm_data", 64'(m_data), 64'd0);
    ready = 1'b1;
    push_val(38'h36);
    chk("rm_next_valid", 64'(m_valid), 64'd1);
    chk("rm_next_data", 64'(m_data), 64'h36);
    step();
    chk("rm_next_popped", 64'(level), 64'd0);

    // Full FIFO: a dump alongside a pop is accepted without overflow.
    do_reset();
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_val(38'(i));
    chk("fp_level_full", 64'(level), 64'd4);
    dump = 1'b1; z = 38'h9; ready = 1'b1;
    step();
    dump = 1'b0; ready = 1'b0;
    chk("fp_level", 64'(level), 64'd4);
    chk("fp_overflow", 64'(overflow), 64'd0);
    chk("fp_head", 64'(m_data), 64'd2);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = (i == 3) ? 32'h9 : 32'(i + 2);
      chk($sformatf("fp_drain%0d", i), 64'(m_data), 64'(e));
      step();
    end
    chk("fp_empty", 64'(m_valid), 64'd0);

    // Latency 2: value on z two cycles after the dump is captured.
    dump2 = 1'b1; z2 = 38'h11;
    step();
    dump2 = 1'b0; z2 = 38'h22;
    step();
    chk("lat2_not_yet", 64'(m_valid2), 64'd0);
    z2 = 38'h55;
    step();
    z2 = 38'h66;
    chk("lat2_valid", 64'(m_valid2), 64'd1);
    chk("lat2_data", 64'(m_data2), 64'h55);
    step();
    chk("lat2_level", 64'(level2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
